tmr_status_unit: RTL and testbench
==================================

// Module: tmr_status_unit
// PURPOSE
//   Downstream of the counter unit. Watches the counter state and the edge
//   that advances it, and predicts wrap events on that same edge.
//   Keeps sticky overflow/underflow status (TSR) with write-1-to-clear.
//   Raises masked interrupt requests to the timer interrupt controller.
// PARAMETERS
//   CNT_W    default `DATA_WIDTH (8)  counter width; must match the counter unit
// PORTS
//   pclk           in   1      system clock; all logic is on its rising edge
//   preset         in   1      synchronous reset, active-high
//   tmr_edge       in   1      1-pclk pulse; marks the pclk edge on which the counter steps
//   count_enable   in   1      counter enable, same value the counter unit sees
//   count_load     in   1      counter load, same value the counter unit sees
//   count_up_down  in   1      0 = up, 1 = down
//   tcnt           in   CNT_W  current counter value, before the step on this edge
//   ovf_ie         in   1      overflow interrupt enable (TIER bit)
//   udf_ie         in   1      underflow interrupt enable (TIER bit)
//   ovf_clr        in   1      1-pclk write-1-to-clear strobe for ovf_flag
//   udf_clr        in   1      1-pclk write-1-to-clear strobe for udf_flag
//   ovf_flag       out  1      sticky overflow status
//   udf_flag       out  1      sticky underflow status
//   ovr_err        out  1      sticky: a wrap occurred while its flag was already set
//   ovf_irq        out  1      ovf_flag & ovf_ie (registered)
//   udf_irq        out  1      udf_flag & udf_ie (registered)
// BEHAVIOUR
//   - Reset (preset=1 on a pclk edge): every flag, ovr_err and irq output = 0.
//     Reset has priority over all other events.
//   - step = tmr_edge & ~count_load & count_enable
//   - ovf_evt = step & ~count_up_down & (tcnt == {CNT_W{1'b1}})
//   - udf_evt = step &  count_up_down & (tcnt == {CNT_W{1'b0}})
//   - A load never generates an event, even when it moves tcnt across 0/max.
//   - Flags go to 1 on the pclk edge after the event: 1-cycle latency.
//   - Flag update: set if evt; else clear if clr; else hold.
//     evt and clr on the same cycle: set wins.
//   - ovr_err is set when ovf_evt & ovf_flag & ~ovf_clr.
//     It is also set on the matching udf condition.
//     It clears only on (ovf_clr & udf_clr) on the same cycle, or on reset.
//   - irq outputs are registered from the next-state flag, so they rise on the
//     same edge as the flag. Clearing an ie bit drops irq on the next edge.
//   - Direction change with no step generates no event. Only the direction
//     sampled on the step cycle counts.
//   - tcnt, count_* and tmr_edge are pclk-synchronous; no CDC inside.
// CONFIGURATION
//   TMR_CMP_MATCH_EN
//     Defined: adds ports tcmp (in, CNT_W), cmp_ie (in), cmp_clr (in),
//     cmp_flag (out) and cmp_irq (out).
//     - cmp_evt = step & (next counter value == tcmp). The next value uses the
//       same wrap rules as the counter: max+1 -> 0, 0-1 -> max.
//     - cmp_flag follows the same set/clear/priority rules as ovf_flag.
//     - cmp_irq = cmp_flag & cmp_ie.
//     - cmp_evt does not affect ovr_err.
//     Undefined: none of these ports or logic exist; all other behaviour is
//     unchanged.
// TESTING
//   1. Up count, tcnt=8'hFF, enable=1, tmr_edge pulse -> ovf_flag=1 next
//      cycle; ovf_irq=1 if ovf_ie=1; udf_flag stays 0.
//   2. Down count, tcnt=8'h00, edge -> udf_flag=1. Then udf_clr pulse ->
//      udf_flag=0 next cycle.
//   3. count_load=1 with tcnt=8'hFF, up, edge -> no flag set.
//      count_enable=0 with tcnt=8'hFF, edge -> no flag set.
//   4. ovf_evt and ovf_clr on the same cycle -> ovf_flag stays 1. A second
//      ovf_evt with the flag still set -> ovr_err=1. Then ovf_clr & udf_clr
//      together -> ovr_err=0 and both flags 0.
//   5. Flags set, preset=1 for one cycle mid-count -> all outputs 0 on the
//      next edge. A simultaneous ovf_evt is ignored.
//   6. (TMR_CMP_MATCH_EN) tcmp=8'h10, up, tcnt=8'h0F, edge -> cmp_flag=1.
//      tcmp=8'h00, up, tcnt=8'hFF -> cmp_flag=1 and ovf_flag=1 together.

Source files
------------

// File: rtl/tmr_status_if.sv
// ---------------------------------------------------------------------------
// tmr_status_if
//   Groups the counter-observation, TIER/TSR control and status/interrupt
//   signals of the timer status unit.
//   Build option: TMR_CMP_MATCH_EN adds the compare-match signals
//   (tcmp, cmp_ie, cmp_clr, cmp_flag, cmp_irq).
//
//   Signals (direction seen from the status unit, modport slave):
//     tmr_edge        in   1-pclk pulse, counter steps on this edge
//     count_enable    in   counter enable as seen by the counter unit
//     count_load      in   counter load as seen by the counter unit
//     count_up_down   in   0 = up, 1 = down
//     tcnt            in   counter value before this edge's step
//     ovf_ie/udf_ie   in   interrupt enables
//     ovf_clr/udf_clr in   write-1-to-clear strobes
//     ovf_flag/udf_flag out sticky status
//     ovr_err         out  sticky overrun status
//     ovf_irq/udf_irq out  masked interrupt requests
//   The master modport is the driving side (counter unit / register file).
// ---------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

interface tmr_status_if #(
  parameter int CNT_W = `DATA_WIDTH
);
  logic             tmr_edge;
  logic             count_enable;
  logic             count_load;
  logic             count_up_down;
  logic [CNT_W-1:0] tcnt;
  logic             ovf_ie;
  logic             udf_ie;
  logic             ovf_clr;
  logic             udf_clr;
  logic             ovf_flag;
  logic             udf_flag;
  logic             ovr_err;
  logic             ovf_irq;
  logic             udf_irq;
`ifdef TMR_CMP_MATCH_EN
  logic [CNT_W-1:0] tcmp;
  logic             cmp_ie;
  logic             cmp_clr;
  logic             cmp_flag;
  logic             cmp_irq;
`endif

  modport master (
    output tmr_edge, count_enable, count_load, count_up_down, tcnt,
    output ovf_ie, udf_ie, ovf_clr, udf_clr,
`ifdef TMR_CMP_MATCH_EN
    output tcmp, cmp_ie, cmp_clr,
    input  cmp_flag, cmp_irq,
`endif
    input  ovf_flag, udf_flag, ovr_err, ovf_irq, udf_irq
  );

  modport slave (
    input  tmr_edge, count_enable, count_load, count_up_down, tcnt,
    input  ovf_ie, udf_ie, ovf_clr, udf_clr,
`ifdef TMR_CMP_MATCH_EN
    input  tcmp, cmp_ie, cmp_clr,
    output cmp_flag, cmp_irq,
`endif
    output ovf_flag, udf_flag, ovr_err, ovf_irq, udf_irq
  );
endinterface

// File: rtl/tmr_status_unit.sv
// ---------------------------------------------------------------------------
// tmr_status_unit
//   Sits downstream of the counter unit. Predicts overflow/underflow wraps on
//   the same pclk edge that steps the counter, keeps sticky TSR status with
//   write-1-to-clear, tracks overrun (wrap while its flag is still set) and
//   drives masked interrupt requests.
//   Build option: TMR_CMP_MATCH_EN adds a compare-match flag/irq based on
//   the counter's next value against tcmp.
//
//   Ports:
//     pclk    in  system clock, rising edge
//     preset  in  synchronous reset, active-high, highest priority
//     bus     tmr_status_if.slave (counter observation, TIER/TSR strobes,
//             status flags and irq outputs)
// ---------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module tmr_status_unit #(
  parameter int CNT_W = `DATA_WIDTH
) (
  input logic         pclk,
  input logic         preset,
  tmr_status_if.slave bus
);

`ifdef TMR_CMP_MATCH_EN
  // Value the counter will hold after this step; wraps max+1 -> 0, 0-1 -> max.
  function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] cnt,
                                                  input logic             down);
    next_count = down ? (cnt - 1'b1) : (cnt + 1'b1);
  endfunction
`endif

  logic step;
  logic ovf_evt;
  logic udf_evt;
  logic ovf_flag_q, ovf_flag_nxt;
  logic udf_flag_q, udf_flag_nxt;
  logic ovr_err_q,  ovr_err_nxt;
  logic ovf_irq_q;
  logic udf_irq_q;

  // Event detection: a load pre-empts the step, so it can never wrap.
  always_comb begin
    step    = bus.tmr_edge & ~bus.count_load & bus.count_enable;
    ovf_evt = step & ~bus.count_up_down & (bus.tcnt == {CNT_W{1'b1}});
    udf_evt = step &  bus.count_up_down & (bus.tcnt == {CNT_W{1'b0}});
  end

  // Next-state status: set beats clear; overrun needs both clears at once.
  always_comb begin
    ovf_flag_nxt = ovf_flag_q;
    udf_flag_nxt = udf_flag_q;
    ovr_err_nxt  = ovr_err_q;

    if (ovf_evt)          ovf_flag_nxt = 1'b1;
    else if (bus.ovf_clr) ovf_flag_nxt = 1'b0;

    if (udf_evt)          udf_flag_nxt = 1'b1;
    else if (bus.udf_clr) udf_flag_nxt = 1'b0;

    // The set terms already exclude a same-cycle clear, so set and the
    // dual-clear condition can never both be true.
    if ((ovf_evt & ovf_flag_q & ~bus.ovf_clr) |
        (udf_evt & udf_flag_q & ~bus.udf_clr))
      ovr_err_nxt = 1'b1;
    else if (bus.ovf_clr & bus.udf_clr)
      ovr_err_nxt = 1'b0;
  end

  // Status register stage: irqs use next-state flags so they rise with them.
  always_ff @(posedge pclk) begin
    if (preset) begin
      ovf_flag_q <= 1'b0;
      udf_flag_q <= 1'b0;
      ovr_err_q  <= 1'b0;
      ovf_irq_q  <= 1'b0;
      udf_irq_q  <= 1'b0;
    end else begin
      ovf_flag_q <= ovf_flag_nxt;
      udf_flag_q <= udf_flag_nxt;
      ovr_err_q  <= ovr_err_nxt;
      ovf_irq_q  <= ovf_flag_nxt & bus.ovf_ie;
      udf_irq_q  <= udf_flag_nxt & bus.udf_ie;
    end
  end

  assign bus.ovf_flag = ovf_flag_q;
  assign bus.udf_flag = udf_flag_q;
  assign bus.ovr_err  = ovr_err_q;
  assign bus.ovf_irq  = ovf_irq_q;
  assign bus.udf_irq  = udf_irq_q;

`ifdef TMR_CMP_MATCH_EN
  logic cmp_evt;
  logic cmp_flag_q, cmp_flag_nxt;
  logic cmp_irq_q;

  always_comb begin
    cmp_evt      = step & (next_count(bus.tcnt, bus.count_up_down) == bus.tcmp);
    cmp_flag_nxt = cmp_flag_q;
    if (cmp_evt)          cmp_flag_nxt = 1'b1;
    else if (bus.cmp_clr) cmp_flag_nxt = 1'b0;
  end

  // Compare status register stage.
  always_ff @(posedge pclk) begin
    if (preset) begin
      cmp_flag_q <= 1'b0;
      cmp_irq_q  <= 1'b0;
    end else begin
      cmp_flag_q <= cmp_flag_nxt;
      cmp_irq_q  <= cmp_flag_nxt & bus.cmp_ie;
    end
  end

  assign bus.cmp_flag = cmp_flag_q;
  assign bus.cmp_irq  = cmp_irq_q;
`endif

endmodule

// File: tb/tb_tmr_status_unit.sv
// ---------------------------------------------------------------------------
// tb_tmr_status_unit
//   Directed bench for tmr_status_unit with hand-computed expectations.
//   Inputs change 1 time unit after a rising edge; outputs are checked at
//   the same point, i.e. after the edge that should have updated them.
//   Build option TMR_CMP_MATCH_EN enables the compare-match vectors.
// ---------------------------------------------------------------------------
module tb_tmr_status_unit;

  logic pclk;
  logic preset;
  int   n_checks;
  int   n_fail;

  tmr_status_if #(.CNT_W(8)) bus ();

  tmr_status_unit #(.CNT_W(8)) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus.slave)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // One counter step with the given direction and pre-step value.
  task automatic do_step(input logic down, input logic [7:0] cnt);
    bus.tmr_edge      = 1'b1;
    bus.count_enable  = 1'b1;
    bus.count_load    = 1'b0;
    bus.count_up_down = down;
    bus.tcnt          = cnt;
    tick();
    bus.tmr_edge      = 1'b0;
  endtask

  task automatic do_clr(input logic o, input logic u);
    bus.ovf_clr = o;
    bus.udf_clr = u;
    tick();
    bus.ovf_clr = 1'b0;
    bus.udf_clr = 1'b0;
  endtask

  initial begin
    n_checks          = 0;
    n_fail            = 0;
    preset            = 1'b1;
    bus.tmr_edge      = 1'b0;
    bus.count_enable  = 1'b0;
    bus.count_load    = 1'b0;
    bus.count_up_down = 1'b0;
    bus.tcnt          = 8'h00;
    bus.ovf_ie        = 1'b0;
    bus.udf_ie        = 1'b0;
    bus.ovf_clr       = 1'b0;
    bus.udf_clr       = 1'b0;
`ifdef TMR_CMP_MATCH_EN
    bus.tcmp          = 8'h00;
    bus.cmp_ie        = 1'b0;
    bus.cmp_clr       = 1'b0;
`endif
    tick();
    tick();
    preset = 1'b0;

    // Reset state
    chk("rst_ovf_flag", bus.ovf_flag, 1'b0);
    chk("rst_udf_flag", bus.udf_flag, 1'b0);
    chk("rst_ovr_err",  bus.ovr_err,  1'b0);
    chk("rst_ovf_irq",  bus.ovf_irq,  1'b0);
    chk("rst_udf_irq",  bus.udf_irq,  1'b0);

    // Up-count overflow at 0xFF
    bus.ovf_ie = 1'b1;
    do_step(1'b0, 8'hFF);
    chk("t1_ovf_flag", bus.ovf_flag, 1'b1);
    chk("t1_ovf_irq",  bus.ovf_irq,  1'b1);
    chk("t1_udf_flag", bus.udf_flag, 1'b0);
    chk("t1_ovr_err",  bus.ovr_err,  1'b0);
    tick();
    chk("t1_ovf_hold", bus.ovf_flag, 1'b1);
    do_clr(1'b1, 1'b0);
    chk("t1_ovf_clr",  bus.ovf_flag, 1'b0);
    chk("t1_irq_clr",  bus.ovf_irq,  1'b0);

    // Down-count underflow at 0x00, irq mask, clear
    bus.udf_ie = 1'b1;
    do_step(1'b1, 8'h00);
    chk("t2_udf_flag", bus.udf_flag, 1'b1);
    chk("t2_udf_irq",  bus.udf_irq,  1'b1);
    chk("t2_ovf_flag", bus.ovf_flag, 1'b0);
    bus.udf_ie = 1'b0;
    tick();
    chk("t2_irq_mask", bus.udf_irq,  1'b0);
    chk("t2_flag_kept", bus.udf_flag, 1'b1);
    do_clr(1'b0, 1'b1);
    chk("t2_udf_clr",  bus.udf_flag, 1'b0);
    bus.udf_ie = 1'b1;

    // Non-wrapping values and wrong direction
    do_step(1'b0, 8'hFE);
    chk("nw_up_fe",    bus.ovf_flag, 1'b0);
    do_step(1'b1, 8'h01);
    chk("nw_dn_01",    bus.udf_flag, 1'b0);
    do_step(1'b1, 8'hFF);
    chk("nw_dn_ff",    bus.ovf_flag, 1'b0);
    do_step(1'b0, 8'h00);
    chk("nw_up_00",    bus.udf_flag, 1'b0);

    // Load, disable and no-edge never produce events
    bus.count_load = 1'b1;
    bus.tmr_edge = 1'b1; bus.count_enable = 1'b1; bus.count_up_down = 1'b0; bus.tcnt = 8'hFF;
    tick();
    bus.tmr_edge = 1'b0; bus.count_load = 1'b0;
    chk("t3_load", bus.ovf_flag, 1'b0);
    bus.tmr_edge = 1'b1; bus.count_enable = 1'b0; bus.tcnt = 8'hFF;
    tick();
    bus.tmr_edge = 1'b0;
    chk("t3_disable", bus.ovf_flag, 1'b0);
    bus.count_enable = 1'b1; bus.tcnt = 8'hFF;
    tick();
    chk("t3_no_edge", bus.ovf_flag, 1'b0);
    bus.count_up_down = 1'b1; bus.tcnt = 8'h00;
    tick();
    chk("t3_dir_only", bus.udf_flag, 1'b0);

    // Set wins over clear, overrun, dual-clear
    bus.ovf_clr = 1'b1;
    do_step(1'b0, 8'hFF);
    bus.ovf_clr = 1'b0;
    chk("t4_set_wins", bus.ovf_flag, 1'b1);
    bus.ovf_clr = 1'b1;
    do_step(1'b0, 8'hFF);
    bus.ovf_clr = 1'b0;
    chk("t4_set_wins2", bus.ovf_flag, 1'b1);
    chk("t4_no_ovr_w_clr", bus.ovr_err, 1'b0);
    do_step(1'b0, 8'hFF);
    chk("t4_ovr_set", bus.ovr_err, 1'b1);
    chk("t4_ovf_still", bus.ovf_flag, 1'b1);
    do_step(1'b1, 8'h00);
    chk("t4_udf_set", bus.udf_flag, 1'b1);
    do_clr(1'b1, 1'b0);
    chk("t4_ovr_keep_o", bus.ovr_err, 1'b1);
    chk("t4_ovf_cleared", bus.ovf_flag, 1'b0);
    do_clr(1'b0, 1'b1);
    chk("t4_ovr_keep_u", bus.ovr_err, 1'b1);
    do_clr(1'b1, 1'b1);
    chk("t4_ovr_clr", bus.ovr_err, 1'b0);
    chk("t4_ovf_0", bus.ovf_flag, 1'b0);
    chk("t4_udf_0", bus.udf_flag, 1'b0);
    // Underflow-side overrun
    do_step(1'b1, 8'h00);
    do_step(1'b1, 8'h00);
    chk("t4_udf_ovr", bus.ovr_err, 1'b1);
    do_clr(1'b1, 1'b1);
    chk("t4_udf_ovr_clr", bus.ovr_err, 1'b0);

    // Reset mid-count beats a simultaneous overflow
    do_step(1'b0, 8'hFF);
    do_step(1'b1, 8'h00);
    chk("t5_pre_ovf", bus.ovf_flag, 1'b1);
    chk("t5_pre_udf", bus.udf_flag, 1'b1);
    preset = 1'b1;
    do_step(1'b0, 8'hFF);
    preset = 1'b0;
    chk("t5_ovf",     bus.ovf_flag, 1'b0);
    chk("t5_udf",     bus.udf_flag, 1'b0);
    chk("t5_ovr",     bus.ovr_err,  1'b0);
    chk("t5_ovf_irq", bus.ovf_irq,  1'b0);
    chk("t5_udf_irq", bus.udf_irq,  1'b0);

`ifdef TMR_CMP_MATCH_EN
    // Compare match on the next counter value
    bus.cmp_ie = 1'b1;
    bus.tcmp   = 8'h10;
    do_step(1'b0, 8'h0F);
    chk("t6_cmp_flag", bus.cmp_flag, 1'b1);
    chk("t6_cmp_irq",  bus.cmp_irq,  1'b1);
    chk("t6_no_ovf",   bus.ovf_flag, 1'b0);
    bus.cmp_clr = 1'b1;
    tick();
    bus.cmp_clr = 1'b0;
    chk("t6_cmp_clr",  bus.cmp_flag, 1'b0);
    do_step(1'b0, 8'h10);
    chk("t6_cmp_miss", bus.cmp_flag, 1'b0);
    bus.tcmp = 8'h00;
    do_step(1'b0, 8'hFF);
    chk("t6_wrap_cmp", bus.cmp_flag, 1'b1);
    chk("t6_wrap_ovf", bus.ovf_flag, 1'b1);
    chk("t6_cmp_no_ovr", bus.ovr_err, 1'b0);
    bus.cmp_clr = 1'b1;
    do_clr(1'b1, 1'b1);
    bus.cmp_clr = 1'b0;
    bus.tcmp = 8'hFF;
    do_step(1'b1, 8'h00);
    chk("t6_dn_cmp", bus.cmp_flag, 1'b1);
    chk("t6_dn_udf", bus.udf_flag, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
